clk_tick_sync: RTL and testbench

Consumer-side companion to the ripple clock divider. Takes the divider's slow tap outputs, which are asynchronous to the system clock, into the `clk` domain through per-channel synchronizers. For each tap it produces a one-cycle rising-edge tick, a saturating stall flag, and a cycle-accurate period measurement for one selected tap. Downstream FSMs (movement/sound sequencing) use `tick` as a clock enable instead of clocking logic from divider outputs directly.

---
 rtl/clk_tick_sync.sv | 138 +++++++++++++
 tb/tb_clk_tick_sync.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_sync.sv
// clk_tick_sync: brings slow ripple-divider taps into the clk domain.
// For each tap it produces a one-cycle rising-edge tick, a saturating stall
// flag and a per-channel cycle counter. The counter of the channel chosen by
// sel is captured as a period measurement on every armed tick of that channel.
module clk_tick_sync #(
  parameter int N           = 5,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 30,
  parameter int SEL_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     clk_in,
  output logic [N-1:0]     tick,
  output logic [N-1:0]     stall,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] period,
  output logic             period_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam int               PRIME_W   = 3;
  localparam logic [PRIME_W-1:0] PRIME_LEN = PRIME_W'(SYNC_STAGES + 1);

  // Synchronizer chain: stage 0 samples the raw taps.
  logic [N-1:0]       sync_r [SYNC_STAGES];
  logic [N-1:0]       prev_r;
  logic [N-1:0]       armed_r;
  logic [N-1:0]       tick_r;
  logic [N-1:0]       stall_r;
  logic [CNT_W-1:0]   cnt_r  [N];
  logic [PRIME_W-1:0] prime_cnt_r;
  logic [CNT_W-1:0]   period_r;
  logic               period_vld_r;

  logic               priming_s;
  logic [N-1:0]       fire_s;
  logic [N-1:0]       sel_hit_s;
  logic [N-1:0]       stall_nxt_s;
  logic [CNT_W-1:0]   cnt_inc_s [N];
  logic [CNT_W-1:0]   cnt_nxt_s [N];
  logic               cap_s;
  logic [CNT_W-1:0]   cap_val_s;

  // Edge detection, counter next-state, stall and capture selection.
  always_comb begin
    priming_s   = (prime_cnt_r != PRIME_LEN);
    fire_s      = '0;
    sel_hit_s   = '0;
    stall_nxt_s = '0;
    cap_val_s   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_inc_s[i] = (cnt_r[i] == CNT_MAX) ? CNT_MAX : (cnt_r[i] + CNT_W'(1));
      cnt_nxt_s[i] = cnt_r[i];
      // While priming, prev is still catching up with the chain, so an
      // apparent edge there is only a tap that was already high at release.
      fire_s[i]    = sync_r[SYNC_STAGES-1][i] & ~prev_r[i] & ~priming_s;
      if (fire_s[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (priming_s) begin
        cnt_nxt_s[i] = cnt_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_inc_s[i];
      end
      stall_nxt_s[i] = (cnt_nxt_s[i] == CNT_MAX);
      sel_hit_s[i]   = (sel == SEL_W'(i));
      cap_val_s      = cap_val_s | (sel_hit_s[i] ? cnt_inc_s[i] : '0);
    end
    // sel values >= N hit no channel, so nothing is captured for them.
    cap_s = |(fire_s & armed_r & sel_hit_s);
  end

  // Synchronizer flops and the history flop behind the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= clk_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Prime counter: runs SYNC_STAGES+1 cycles after reset release, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt_r <= '0;
    end else if (priming_s) begin
      prime_cnt_r <= prime_cnt_r + PRIME_W'(1);
    end else begin
      prime_cnt_r <= prime_cnt_r;
    end
  end

  // Per-channel cycle counters, arming, registered tick and stall outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
      end
      armed_r <= '0;
      tick_r  <= '0;
      stall_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      armed_r <= armed_r | fire_s;
      tick_r  <= fire_s;
      stall_r <= stall_nxt_s;
    end
  end

  // Period capture for the selected channel, coincident with its tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r     <= '0;
      period_vld_r <= 1'b0;
    end else if (cap_s) begin
      period_r     <= cap_val_s;
      period_vld_r <= 1'b1;
    end else begin
      period_r     <= period_r;
      period_vld_r <= 1'b0;
    end
  end

  assign tick       = tick_r;
  assign stall      = stall_r;
  assign period     = period_r;
  assign period_vld = period_vld_r;

endmodule

// File: tb/tb_clk_tick_sync.sv
// Scoreboard bench for clk_tick_sync: a reference model keyed on sampled
// input history and edge indices pushes expected tick/stall/period events;
// a monitor pops them as the DUT presents outputs.
module tb_clk_tick_sync;

  localparam int N    = 5;
  localparam int S    = 2;
  localparam int CW   = 6;
  localparam int SW   = 3;
  localparam int MAXI = (1 << CW) - 1;

  typedef struct { int e; logic [N-1:0] v; } vev_t;
  typedef struct { int e; logic [CW-1:0] p; } pev_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  clk_in_d;
  logic [N-1:0]  tick;
  logic [N-1:0]  stall;
  logic [SW-1:0] sel;
  logic [CW-1:0] period;
  logic          period_vld;

  int checks   = 0;
  int failures = 0;

  vev_t tick_q[$];
  vev_t stall_q[$];
  pev_t per_q[$];

  logic [N-1:0] hist[$];
  int           edge_idx = 0;
  int           last_t[N];
  bit           armed_m[N];
  logic [N-1:0] stall_m;

  int  half[N];
  int  hcnt[N];
  bit  rand_mode = 1'b0;

  clk_tick_sync #(.N(N), .SYNC_STAGES(S), .CNT_W(CW), .SEL_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in_d),
    .tick       (tick),
    .stall      (stall),
    .sel        (sel),
    .period     (period),
    .period_vld (period_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic hs(input int k, input int i);
    if (k < 0) return 1'b0;
    return hist[k][i];
  endfunction

  function automatic int pick();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(60, 90));
    return int'($urandom_range(2, 30));
  endfunction

  // Reference model: a tick follows a sampled 0->1 of the input S edges
  // later, unless that edge lies in the first S+1 edges after release.
  initial begin
    int e, ref_e, age;
    logic [N-1:0] tvec, svec;
    bit rise;
    stall_m = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edge_idx = 0;
        hist.delete();
        tick_q.delete();
        stall_q.delete();
        per_q.delete();
        stall_m = '0;
        for (int i = 0; i < N; i++) begin
          armed_m[i] = 1'b0;
          last_t[i]  = 0;
        end
      end else begin
        e = edge_idx;
        hist.push_back(clk_in_d);
        tvec = '0;
        svec = '0;
        for (int i = 0; i < N; i++) begin
          rise  = (e >= S + 1) && hs(e - S, i) && !hs(e - S - 1, i);
          ref_e = armed_m[i] ? last_t[i] : S;
          age   = e - ref_e;
          if (age > MAXI) age = MAXI;
          if (rise) begin
            tvec[i] = 1'b1;
            if (armed_m[i] && int'(sel) == i) per_q.push_back('{e, CW'(age)});
            armed_m[i] = 1'b1;
            last_t[i]  = e;
          end else begin
            svec[i] = (age == MAXI);
          end
        end
        if (tvec != '0) tick_q.push_back('{e, tvec});
        if (svec != stall_m) begin
          stall_q.push_back('{e, svec});
          stall_m = svec;
        end
        edge_idx = edge_idx + 1;
      end
    end
  end

  // Monitor: compares DUT events against the scoreboard queues.
  initial begin
    logic [N-1:0] prev_st;
    int e;
    vev_t tv;
    pev_t pv;
    prev_st = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || edge_idx == 0) begin
        prev_st = '0;
      end else begin
        e = edge_idx - 1;
        if (tick_q.size() > 0 && tick_q[0].e < e) begin
          tv = tick_q.pop_front();
          check("tick_missing_edge", e, tv.e);
        end
        if (stall_q.size() > 0 && stall_q[0].e < e) begin
          tv = stall_q.pop_front();
          check("stall_missing_edge", e, tv.e);
        end
        if (per_q.size() > 0 && per_q[0].e < e) begin
          pv = per_q.pop_front();
          check("period_missing_edge", e, pv.e);
        end
        if (tick != '0) begin
          if (tick_q.size() == 0) begin
            check("tick_unexpected", tick, 0);
          end else begin
            tv = tick_q.pop_front();
            check("tick_edge", e, tv.e);
            check("tick_vec", tick, tv.v);
          end
        end
        if (stall != prev_st) begin
          prev_st = stall;
          if (stall_q.size() == 0) begin
            check("stall_unexpected", stall, stall_m);
          end else begin
            tv = stall_q.pop_front();
            check("stall_edge", e, tv.e);
            check("stall_vec", stall, tv.v);
          end
        end
        if (period_vld) begin
          if (per_q.size() == 0) begin
            check("period_vld_unexpected", period_vld, 0);
          end else begin
            pv = per_q.pop_front();
            check("period_edge", e, pv.e);
            check("period_val", period, pv.p);
          end
        end
      end
    end
  end

  task automatic step();
    for (int i = 0; i < N; i++) begin
      if (half[i] != 0) begin
        hcnt[i]++;
        if (hcnt[i] >= half[i]) begin
          clk_in_d[i] = ~clk_in_d[i];
          hcnt[i] = 0;
          if (rand_mode) half[i] = pick();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_period_vld"}, period_vld, 0);
  endtask

  task automatic do_reset();
    #1;
    check("pending_tick_before_reset", tick_q.size(), 0);
    check("pending_stall_before_reset", stall_q.size(), 0);
    check("pending_period_before_reset", per_q.size(), 0);
    rst_n = 1'b0;
    #1;
    outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    sel      = '0;
    clk_in_d = 5'b00010;
    for (int i = 0; i < N; i++) begin
      half[i] = 0;
      hcnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    rst_n = 1'b1;

    // Fixed scenarios: ch0 period 16, ch1 high through release,
    // ch2 idle until it stalls, then pulses twice while sel=0.
    for (int c = 0; c < 150; c++) begin
      clk_in_d[0] = ((c / 8) % 2) == 1;
      clk_in_d[1] = !(c >= 10 && c < 20);
      clk_in_d[2] = (c >= 110 && c < 120) || (c >= 130);
      @(negedge clk);
    end

    // Sel switch: ch3 period 10, ch4 period 80 (saturates the counter).
    half[3] = 5;
    half[4] = 40;
    sel = 3'd3;
    repeat (120) step();
    sel = 3'd4;
    repeat (300) step();

    // Randomized toggling and sel, with a one-cycle reset mid-run.
    rand_mode = 1'b1;
    for (int i = 0; i < N; i++) begin
      half[i] = pick();
      hcnt[i] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) sel = SW'($urandom_range(0, 7));
      if (c == 700) do_reset();
      step();
    end

    #1;
    check("leftover_tick", tick_q.size(), 0);
    check("leftover_stall", stall_q.size(), 0);
    check("leftover_period", per_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
